trig_scale_unit: RTL and testbench

//   Parametrised successor to the CUD cosine/distance unit. Computes result = v*cos(x) or v*sin(x).

---
 rtl/trig_pkg.sv | 26 ++
 rtl/fx_mul_rs.sv | 39 +++
 rtl/trig_scale_unit.sv | 161 ++++++++++++++++
 tb/tb_trig_scale_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared types and constants for trig_scale_unit.
//   state_t   : sequencer states of the iterative Taylor engine
//   rcp_const : rounded Q(f) reciprocal 1/((2k-1)(2k)) for cos or 1/((2k)(2k+1)) for sin
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XSQ,
        MUL_X2,
        MUL_RCP,
        SCALE,
        FIN
    } state_t;

    // Only ever evaluated at elaboration time to build constant tables.
    // k = 0 has no meaning for cos (divisor 0) and returns 0.
    function automatic int rcp_const(input int k, input logic mode, input int f);
        int d;
        if (k < 1) begin
            return 0;
        end
        d = mode ? (2 * k) * (2 * k + 1) : (2 * k - 1) * (2 * k);
        return ((1 << f) + d / 2) / d;
    endfunction

endpackage

// File: rtl/fx_mul_rs.sv
// fx_mul_rs: combinational signed fixed-point multiply with round-half-up and saturation.
//   a, b : W-bit two's complement operands in Q(F)
//   p    : W-bit Q(F) product, saturated to [-2^(W-1), 2^(W-1)-1]
//   sat  : high when p was clamped
module fx_mul_rs #(
    parameter int W = 16,
    parameter int F = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         sat
);

    localparam logic signed [2*W-1:0] RND = {{(2*W-1){1'b0}}, 1'b1} << (F - 1);

    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_r;
    logic        [W-F:0]   top;

    assign ae     = $signed(a);
    assign be     = $signed(b);
    assign prod   = ae * be;
    assign prod_r = prod + RND;
    // Bits above the kept field must all equal its sign bit, else the value is out of range.
    assign top    = prod_r[2*W-1:F+W-1];

    always_comb begin
        sat = !((&top) || !(|top));
        if (sat) begin
            p = prod_r[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            p = prod_r[F+W-1:F];
        end
    end

endmodule

// File: rtl/trig_scale_unit.sv
// trig_scale_unit: result = v*cos(x) (mode 0) or v*sin(x) (mode 1) in Q(W-F).F.
// Iterative Taylor series sharing a single fx_mul_rs; fixed latency.
//   clk, rst         : clock, async active-high reset
//   start, mode      : rising-edge-qualified request and function select
//   v_in, x_in       : scale and angle operands, captured at launch
//   busy             : high from launch until the done cycle
//   done             : one-cycle pulse; result/overflow valid from then on
//   result, overflow : held until the next done or reset
module trig_scale_unit
    import trig_pkg::*;
#(
    parameter int W       = 16,
    parameter int F       = 11,
    parameter int N_TERMS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] v_in,
    input  logic [W-1:0] x_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow
);

    localparam int KW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << F;
    localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);

    state_t        state, state_n;
    logic          start_d, launch, mode_r;
    logic [KW-1:0] k;
    logic [W-1:0]  v_r, x_r, x2, term, acc, result_n;
    logic [W-1:0]  mul_a, mul_b, mul_p, rcp_k;
    logic          mul_sat, add_sat;
    logic [W:0]    sum;
    logic [W-1:0]  acc_n;

    // Reciprocal tables, elaboration-time constants indexed by the term counter.
    logic [W-1:0] rcp_cos [2**KW];
    logic [W-1:0] rcp_sin [2**KW];
    for (genvar g = 0; g < 2**KW; g++) begin : g_rcp
        assign rcp_cos[g] = W'(rcp_const(g, 1'b0, F));
        assign rcp_sin[g] = W'(rcp_const(g, 1'b1, F));
    end
    assign rcp_k = mode_r ? rcp_sin[k] : rcp_cos[k];

    assign launch = (state == IDLE) && start && !start_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (launch) state_n = XSQ;
            XSQ:     state_n = (N_TERMS > 1) ? MUL_X2 : SCALE;
            MUL_X2:  state_n = MUL_RCP;
            MUL_RCP: state_n = (k == K_LAST) ? SCALE : MUL_X2;
            SCALE:   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Shared multiplier operand select
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            XSQ:     begin mul_a = x_r;  mul_b = x_r;   end
            MUL_X2:  begin mul_a = term; mul_b = x2;    end
            MUL_RCP: begin mul_a = term; mul_b = rcp_k; end
            SCALE:   begin mul_a = v_r;  mul_b = acc;   end
            default: ;
        endcase
    end

    fx_mul_rs #(.W(W), .F(F)) u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .sat (mul_sat)
    );

    // Alternating-sign accumulate: odd k subtracts. One guard bit detects overflow.
    always_comb begin
        sum     = k[0] ? ({acc[W-1], acc} - {mul_p[W-1], mul_p})
                       : ({acc[W-1], acc} + {mul_p[W-1], mul_p});
        add_sat = sum[W] ^ sum[W-1];
        if (add_sat) acc_n = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else         acc_n = sum[W-1:0];
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d  <= 1'b0;
            mode_r   <= 1'b0;
            k        <= '0;
            v_r      <= '0;
            x_r      <= '0;
            x2       <= '0;
            term     <= '0;
            acc      <= '0;
            result_n <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            start_d <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        v_r      <= v_in;
                        x_r      <= x_in;
                        mode_r   <= mode;
                        term     <= mode ? x_in : ONE;
                        acc      <= mode ? x_in : ONE;
                        k        <= KW'(1);
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                XSQ: begin
                    x2 <= mul_p;
                    if (mul_sat) overflow <= 1'b1;
                end
                MUL_X2: begin
                    term <= mul_p;
                    if (mul_sat) overflow <= 1'b1;
                end
                MUL_RCP: begin
                    term <= mul_p;
                    acc  <= acc_n;
                    k    <= k + KW'(1);
                    if (mul_sat || add_sat) overflow <= 1'b1;
                end
                SCALE: begin
                    result_n <= mul_p;
                    if (mul_sat) overflow <= 1'b1;
                end
                FIN: begin
                    result <= result_n;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_scale_unit.sv
module tb_trig_scale_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] v_in;
    logic [15:0] x_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    trig_scale_unit #(.W(16), .F(11), .N_TERMS(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .v_in     (v_in),
        .x_in     (x_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (Q5.11 arithmetic rules) ----------------
    function automatic int sat16(input longint s, inout bit o);
        if (s > 32767)  begin o = 1'b1; return 32767;  end
        if (s < -32768) begin o = 1'b1; return -32768; end
        return int'(s);
    endfunction

    function automatic int mrs(input int a, input int b, inout bit o);
        longint p;
        p = longint'(a) * longint'(b) + 1024;
        return sat16(p >>> 11, o);
    endfunction

    function automatic int rcp(input int k, input bit m);
        real d;
        d = m ? real'((2 * k) * (2 * k + 1)) : real'((2 * k - 1) * (2 * k));
        return $rtoi(2048.0 / d + 0.5);
    endfunction

    function automatic void model(input int v, input int x, input bit m,
                                  output int r, output bit o);
        int x2, term, acc;
        o    = 1'b0;
        x2   = mrs(x, x, o);
        term = m ? x : 2048;
        acc  = term;
        for (int k = 1; k <= 5; k++) begin
            term = mrs(term, x2, o);
            term = mrs(term, rcp(k, m), o);
            acc  = sat16((k % 2 == 1) ? longint'(acc) - term : longint'(acc) + term, o);
        end
        r = mrs(v, acc, o);
    endfunction

    // ---------------- stimulus driver (no comparisons) ----------------
    // Edge n=1 is the launch edge; outputs are sampled 1 time unit after each edge.
    // start is high for edges 1..hold and additionally at edge pulse_at+1.
    task automatic run_op(input logic [15:0] v, input logic [15:0] x, input logic m,
                          input int hold, input int pulse_at, input int ncyc,
                          output int r, output bit o, output int lat,
                          output int ndone, output bit busy1, output bit busyd);
        @(negedge clk);
        v_in = v; x_in = x; mode = m; start = 1'b1;
        lat = -1; ndone = 0; r = 0; o = 1'b0; busy1 = 1'b0; busyd = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            start = (n < hold) || (n == pulse_at);
            if (n == 1) busy1 = busy;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n; r = int'($signed(result)); o = overflow; busyd = busy;
                end
            end
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; v_in = '0; x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, overflow} !== 3'b000 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b ovf=%b result=%h, required all 0",
                     busy, done, overflow, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_directed(input string name, input logic [15:0] v, input logic [15:0] x,
                                  input logic m, input int approx, input bit use_approx);
        int r, lat, nd, er, d; bit o, eo, b1, bd;
        model(int'($signed(v)), int'($signed(x)), m, er, eo);
        run_op(v, x, m, 1, -1, 20, r, o, lat, nd, b1, bd);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL %s_latency: got %0d required 14", name, lat); end
        checks++;
        if (r !== er || o !== eo) begin
            errors++;
            $display("FAIL %s_value: got %0d ovf=%b required %0d ovf=%b", name, r, o, er, eo);
        end
        checks++;
        if (b1 !== 1'b1 || bd !== 1'b0 || nd !== 1) begin
            errors++;
            $display("FAIL %s_handshake: busy1=%b busy_at_done=%b pulses=%0d required 1,0,1",
                     name, b1, bd, nd);
        end
        if (use_approx) begin
            d = r - approx; if (d < 0) d = -d;
            checks++;
            if (d > 4) begin
                errors++;
                $display("FAIL %s_accuracy: got %0d required %0d +/-4", name, r, approx);
            end
        end
    endtask

    task automatic test_cos_basic();
        check_directed("cos_0p5", 16'h0800, 16'h0400, 1'b0, 1797, 1'b1);
    endtask

    task automatic test_cos_neg_scale();
        check_directed("cos_neg", 16'hF400, 16'h0946, 1'b0, -1229, 1'b1);
    endtask

    task automatic test_sin();
        check_directed("sin_pi6", 16'h1000, 16'h0430, 1'b1, 2048, 1'b1);
        check_directed("cos_pi6", 16'h1000, 16'h0430, 1'b0, 3547, 1'b1);
    endtask

    task automatic test_overflow();
        int r, lat, nd; bit o, b1, bd;
        check_directed("cos_x5", 16'h0800, 16'h2800, 1'b0, 0, 1'b0);
        run_op(16'h0800, 16'h2800, 1'b0, 1, -1, 20, r, o, lat, nd, b1, bd);
        checks++;
        if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", o); end
        // sticky flag must clear on the next launch
        run_op(16'h0800, 16'h0400, 1'b0, 1, -1, 20, r, o, lat, nd, b1, bd);
        checks++;
        if (o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", o); end
        check_directed("vmin_cos", 16'h8000, 16'h0400, 1'b0, 0, 1'b0);
        check_directed("vmin_x0", 16'h8000, 16'h0000, 1'b0, -32768, 1'b1);
    endtask

    task automatic test_start_qualify();
        int r, lat, nd, er; bit o, b1, bd, eo;
        model(2048, 1024, 1'b0, er, eo);
        run_op(16'h0800, 16'h0400, 1'b0, 3, -1, 35, r, o, lat, nd, b1, bd);
        checks++;
        if (nd !== 1 || lat !== 14) begin
            errors++; $display("FAIL held3: pulses=%0d lat=%0d required 1,14", nd, lat);
        end
        run_op(16'h0800, 16'h0400, 1'b0, 1, 5, 35, r, o, lat, nd, b1, bd);
        checks++;
        if (nd !== 1 || r !== er) begin
            errors++; $display("FAIL busy_pulse: pulses=%0d result=%0d required 1,%0d", nd, r, er);
        end
        // start held past FIN: no relaunch until it falls
        run_op(16'h0800, 16'h0400, 1'b0, 25, -1, 35, r, o, lat, nd, b1, bd);
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL held_fin: pulses=%0d required 1", nd); end
        model(4096, 1072, 1'b1, er, eo);
        run_op(16'h1000, 16'h0430, 1'b1, 1, -1, 20, r, o, lat, nd, b1, bd);
        checks++;
        if (nd !== 1 || r !== er || lat !== 14) begin
            errors++; $display("FAIL second_op: pulses=%0d result=%0d lat=%0d required 1,%0d,14",
                               nd, r, lat, er);
        end
    endtask

    task automatic test_rst_abort();
        int r, lat, nd, er; bit o, b1, bd, eo;
        @(negedge clk);
        v_in = 16'h0800; x_in = 16'h0400; mode = 1'b0; start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, overflow} !== 3'b000 || result !== 16'h0000) begin
            errors++;
            $display("FAIL rst_abort: busy=%b done=%b ovf=%b result=%h, required all 0",
                     busy, done, overflow, result);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL rst_no_done: pulses=%0d required 0", nd); end
        model(2048, 1024, 1'b0, er, eo);
        run_op(16'h0800, 16'h0400, 1'b0, 1, -1, 20, r, o, lat, nd, b1, bd);
        checks++;
        if (r !== er || lat !== 14) begin
            errors++; $display("FAIL rst_relaunch: result=%0d lat=%0d required %0d,14", r, lat, er);
        end
    endtask

    task automatic test_random();
        int r, lat, nd, er, xi; bit o, b1, bd, eo;
        logic [15:0] v, x; logic m;
        for (int i = 0; i < 40; i++) begin
            v  = 16'($urandom);
            xi = (i < 34) ? int'($urandom_range(12868)) - 6434 : int'($urandom_range(65535)) - 32768;
            x  = 16'(xi);
            m  = 1'($urandom);
            model(int'($signed(v)), int'($signed(x)), m, er, eo);
            run_op(v, x, m, 1, -1, 16, r, o, lat, nd, b1, bd);
            checks++;
            if (r !== er || o !== eo || lat !== 14) begin
                errors++;
                $display("FAIL random%0d: v=%h x=%h m=%b got %0d ovf=%b lat=%0d required %0d ovf=%b lat=14",
                         i, v, x, m, r, o, lat, er, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cos_basic();
        test_cos_neg_scale();
        test_sin();
        test_overflow();
        test_start_qualify();
        test_rst_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
